// File: rtl/memory_stage.sv
// Memory stage: issues data-bus requests and aligns load/store lanes.
// Optional MEM_MISALIGN_CHECK_EN traps misaligned accesses instead of aligning.

package mem_pkg;

  typedef logic [63:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] msize;
    logic       mem_unsigned;
  } ctl_t;

  typedef struct packed {
    word_t      pc;
    ctl_t       ctl;
    word_t      result_alu;
    word_t      wd;
    creg_addr_t wa;
  } execute_data_t;

  typedef struct packed {
    logic       valid;
    word_t      addr;
    logic [2:0] size;
    logic [7:0] strobe;
    word_t      data;
  } dbus_req_t;

  typedef struct packed {
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    word_t      pc;
    ctl_t       ctl;
    word_t      result;
    creg_addr_t wa;
    logic       misalign;
  } memory_data_t;

  typedef struct packed {
    creg_addr_t waM;
    word_t      resultM;
    logic       regwriteM;
    logic       loadbusyM;
  } forward_data_t;

endpackage

module memory_stage
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          dataE_valid,
  input  execute_data_t dataE,
  output logic          dataE_ready,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output logic          dataM_valid,
  output memory_data_t  dataM,
  input  logic          dataM_ready,
  output forward_data_t forward
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  typedef struct packed {
    word_t      pc;
    ctl_t       ctl;
    word_t      alu;
    creg_addr_t wa;
    word_t      addr;
    logic [7:0] strobe;
    word_t      data;
  } pend_t;

  state_e       state_q, state_d;
  pend_t        pend_q, pend_d;
  memory_data_t dataM_q, dataM_d;
  logic         dataM_valid_q, dataM_valid_d;

  logic       accept;
  logic       is_mem;
  logic       mis;
  logic       done;
  logic       go_bus;
  word_t      amask;
  word_t      eaddr;
  word_t      sdata;
  word_t      lsh;
  word_t      ldata;
  logic [7:0] bmask;
  logic [7:0] strobe;
  logic [2:0] off;

  always_comb begin
    amask = ~64'h0;
    bmask = 8'h01;
    unique case (dataE.ctl.msize)
      2'd0: begin
        amask = ~64'h0;
        bmask = 8'h01;
      end
      2'd1: begin
        amask = ~64'h1;
        bmask = 8'h03;
      end
      2'd2: begin
        amask = ~64'h3;
        bmask = 8'h0F;
      end
      default: begin
        amask = ~64'h7;
        bmask = 8'hFF;
      end
    endcase
    eaddr  = dataE.result_alu & amask;
    off    = eaddr[2:0];
    is_mem = dataE.ctl.memread | dataE.ctl.memwrite;
    strobe = dataE.ctl.memwrite ? (bmask << off) : 8'h00;
    sdata  = dataE.wd << {off, 3'b000};
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = is_mem && (dataE.result_alu != eaddr);
`else
  assign mis = 1'b0;
`endif

  // Lane extraction uses the aligned address captured at accept time
  always_comb begin
    lsh   = dresp.data >> {pend_q.addr[2:0], 3'b000};
    ldata = lsh;
    unique case (pend_q.ctl.msize)
      2'd0: ldata = pend_q.ctl.mem_unsigned ?
                    {56'b0, lsh[7:0]} :
                    {{56{lsh[7]}}, lsh[7:0]};
      2'd1: ldata = pend_q.ctl.mem_unsigned ?
                    {48'b0, lsh[15:0]} :
                    {{48{lsh[15]}}, lsh[15:0]};
      2'd2: ldata = pend_q.ctl.mem_unsigned ?
                    {32'b0, lsh[31:0]} :
                    {{32{lsh[31]}}, lsh[31:0]};
      default: ldata = lsh;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go_bus) state_d = WAIT;
      WAIT: if (dresp.data_ok) state_d = IDLE;
    endcase
  end

  always_comb begin
    dataE_ready = (state_q == IDLE) &&
                  (!dataM_valid_q || dataM_ready);
    accept      = dataE_valid && dataE_ready;
    go_bus      = accept && is_mem && !mis;
    done        = (state_q == WAIT) && dresp.data_ok;
    dreq.valid  = (state_q == WAIT);
    dreq.addr   = pend_q.addr;
    dreq.size   = {1'b0, pend_q.ctl.msize};
    dreq.strobe = pend_q.strobe;
    dreq.data   = pend_q.data;
    forward.waM       = dataM_q.wa;
    forward.resultM   = dataM_q.result;
    forward.regwriteM = dataM_valid_q && dataM_q.ctl.regwrite;
    forward.loadbusyM = (state_q == WAIT) && pend_q.ctl.memread;
  end

  always_comb begin
    pend_d = pend_q;
    if (go_bus) begin
      pend_d.pc     = dataE.pc;
      pend_d.ctl    = dataE.ctl;
      pend_d.alu    = dataE.result_alu;
      pend_d.wa     = dataE.wa;
      pend_d.addr   = eaddr;
      pend_d.strobe = strobe;
      pend_d.data   = sdata;
    end
  end

  // Output register: drains on dataM_ready, reloads from bus or execute
  always_comb begin
    dataM_d       = dataM_q;
    dataM_valid_d = dataM_valid_q && !dataM_ready;
    if (done) begin
      dataM_d.pc       = pend_q.pc;
      dataM_d.ctl      = pend_q.ctl;
      dataM_d.result   = pend_q.ctl.memread ? ldata : pend_q.alu;
      dataM_d.wa       = pend_q.wa;
      dataM_d.misalign = 1'b0;
      dataM_valid_d    = 1'b1;
    end else if (accept && !go_bus) begin
      dataM_d.pc       = dataE.pc;
      dataM_d.ctl      = dataE.ctl;
      dataM_d.result   = dataE.result_alu;
      dataM_d.wa       = dataE.wa;
      dataM_d.misalign = mis;
      if (mis) dataM_d.ctl.regwrite = 1'b0;
      dataM_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q        <= '0;
      dataM_q       <= '0;
      dataM_valid_q <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      dataM_q       <= dataM_d;
      dataM_valid_q <= dataM_valid_d;
    end
  end

  assign dataM       = dataM_q;
  assign dataM_valid = dataM_valid_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed loads, stores, stalls, reset.
// A bus responder answers requests; a monitor checks every consumed dataM.

module tb_memory_stage;
  import mem_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          dataE_valid;
  execute_data_t dataE;
  logic          dataE_ready;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  logic          dataM_valid;
  memory_data_t  dataM;
  logic          dataM_ready;
  forward_data_t forward;

  int checks = 0;
  int errors = 0;
  memory_data_t sb[$];

  logic      resp_en;
  logic      resp_ok;
  logic      force_ok;
  logic      chk_req;
  logic      exp_load;
  int        resp_lat;
  word_t     resp_data;
  dbus_req_t exp_req;
  dbus_req_t first_req;
  int        cnt;
  int        valid_cycles;

  assign dresp = {resp_ok | force_ok, resp_data};

  always #5 clk = ~clk;

  memory_stage dut (
    .clk         (clk),
    .reset       (reset),
    .dataE_valid (dataE_valid),
    .dataE       (dataE),
    .dataE_ready (dataE_ready),
    .dreq        (dreq),
    .dresp       (dresp),
    .dataM_valid (dataM_valid),
    .dataM       (dataM),
    .dataM_ready (dataM_ready),
    .forward     (forward)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic execute_data_t mk(
    input word_t pc, input logic rw, input logic mr,
    input logic mw, input logic [1:0] ms, input logic uns,
    input word_t alu, input word_t wd, input creg_addr_t wa);
    execute_data_t e;
    e.pc = pc;
    e.ctl.regwrite = rw;
    e.ctl.memread = mr;
    e.ctl.memwrite = mw;
    e.ctl.msize = ms;
    e.ctl.mem_unsigned = uns;
    e.result_alu = alu;
    e.wd = wd;
    e.wa = wa;
    return e;
  endfunction

  function automatic memory_data_t exp_of(
    input execute_data_t e, input word_t res, input logic mis);
    memory_data_t m;
    m.pc = e.pc;
    m.ctl = e.ctl;
    if (mis) m.ctl.regwrite = 1'b0;
    m.result = res;
    m.wa = e.wa;
    m.misalign = mis;
    return m;
  endfunction

  function automatic dbus_req_t mkreq(
    input word_t a, input logic [2:0] s,
    input logic [7:0] st, input word_t d);
    dbus_req_t r;
    r.valid = 1'b1;
    r.addr = a;
    r.size = s;
    r.strobe = st;
    r.data = d;
    return r;
  endfunction

  task automatic issue(input execute_data_t e,
                       input memory_data_t m,
                       input bit push);
    int n;
    n = 0;
    if (push) sb.push_back(m);
    dataE = e;
    dataE_valid = 1'b1;
    @(negedge clk);
    while (!dataE_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_accept", dataE_ready, 1);
    @(posedge clk);
    #1;
    dataE_valid = 1'b0;
    dataE = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic memop(input execute_data_t e, input dbus_req_t r,
                       input int lat, input word_t rdata,
                       input word_t res);
    exp_req = r;
    chk_req = 1'b1;
    exp_load = e.ctl.memread;
    resp_lat = lat;
    resp_data = rdata;
    resp_en = 1'b1;
    issue(e, exp_of(e, res, 1'b0), 1'b1);
    drain();
  endtask

  // Bus responder: answers resp_lat cycles after the first valid cycle
  initial begin
    cnt = 0;
    resp_ok = 1'b0;
    valid_cycles = 0;
    forever begin
      @(posedge clk);
      #1;
      resp_ok = 1'b0;
      if (reset || !dreq.valid) begin
        cnt = 0;
      end else begin
        cnt++;
        valid_cycles++;
        check("ready_in_wait", dataE_ready, 0);
        if (cnt == 1) begin
          first_req = dreq;
          if (chk_req) begin
            check("req_addr", dreq.addr, exp_req.addr);
            check("req_size", dreq.size, exp_req.size);
            check("req_strobe", dreq.strobe, exp_req.strobe);
            check("req_data", dreq.data, exp_req.data);
            check("loadbusy", forward.loadbusyM, exp_load);
          end
        end
        if (resp_en && cnt == resp_lat + 1) begin
          resp_ok = 1'b1;
          check("stable_addr", dreq.addr, first_req.addr);
          check("stable_strobe", dreq.strobe, first_req.strobe);
          check("stable_data", dreq.data, first_req.data);
        end
      end
    end
  end

  // Monitor: compares each consumed dataM against the scoreboard
  initial begin
    memory_data_t m;
    memory_data_t held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset && dataM_valid) begin
        if (stalled) begin
          check("hold_pc", dataM.pc, held.pc);
          check("hold_result", dataM.result, held.result);
        end
        if (dataM_ready) begin
          stalled = 1'b0;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_output: got pc %h expected none",
                     dataM.pc);
          end else begin
            m = sb.pop_front();
            check("out_pc", dataM.pc, m.pc);
            check("out_result", dataM.result, m.result);
            check("out_wa", dataM.wa, m.wa);
            check("out_ctl", dataM.ctl, m.ctl);
            check("out_misalign", dataM.misalign, m.misalign);
          end
        end else begin
          stalled = 1'b1;
          held = dataM;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    execute_data_t e;
    execute_data_t eb;
    int vc;
    reset = 1'b1;
    dataE = '0;
    dataE_valid = 1'b0;
    dataM_ready = 1'b1;
    force_ok = 1'b0;
    resp_en = 1'b1;
    chk_req = 1'b0;
    exp_load = 1'b0;
    resp_lat = 0;
    resp_data = '0;
    exp_req = '0;
    #2;
    check("rst_dreq_valid", dreq.valid, 0);
    check("rst_dataM_valid", dataM_valid, 0);
    check("rst_dataM_zero", dataM == '0, 1);
    check("rst_forward_zero", forward == '0, 1);
    check("rst_ready", dataE_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    e = mk(64'h100, 1, 0, 0, 0, 0, 64'h5, 0, 5'd3);
    issue(e, exp_of(e, 64'h5, 0), 1'b1);
    @(negedge clk);
    check("alu_valid", dataM_valid, 1);
    check("alu_resultM", forward.resultM, 64'h5);
    check("alu_regwriteM", forward.regwriteM, 1);
    check("alu_waM", forward.waM, 3);
    @(posedge clk);
    #1;

    memop(mk(64'h104, 1, 1, 0, 0, 0, 64'h1003, 0, 5'd5),
          mkreq(64'h1003, 3'd0, 8'h00, 64'h0),
          2, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    memop(mk(64'h108, 0, 0, 1, 1, 0, 64'h1002, 64'hABCD, 5'd0),
          mkreq(64'h1002, 3'd1, 8'h0C, 64'hABCD_0000),
          3, 64'h0, 64'h1002);
    memop(mk(64'h10C, 1, 1, 0, 0, 1, 64'h2005, 0, 5'd6),
          mkreq(64'h2005, 3'd0, 8'h00, 64'h0),
          0, 64'h0011_2233_4455_6677, 64'h22);
    memop(mk(64'h110, 1, 1, 0, 2, 0, 64'h3004, 0, 5'd7),
          mkreq(64'h3004, 3'd2, 8'h00, 64'h0),
          1, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    memop(mk(64'h114, 1, 1, 0, 3, 0, 64'h4000, 0, 5'd8),
          mkreq(64'h4000, 3'd3, 8'h00, 64'h0),
          1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    memop(mk(64'h118, 0, 0, 1, 3, 0, 64'h5008,
             64'h1122_3344_5566_7788, 5'd0),
          mkreq(64'h5008, 3'd3, 8'hFF, 64'h1122_3344_5566_7788),
          0, 64'h0, 64'h5008);
    memop(mk(64'h11C, 0, 0, 1, 0, 0, 64'h5007, 64'hAB, 5'd0),
          mkreq(64'h5007, 3'd0, 8'h80, 64'hAB00_0000_0000_0000),
          2, 64'h0, 64'h5007);
    memop(mk(64'h120, 1, 1, 0, 1, 0, 64'h6006, 0, 5'd9),
          mkreq(64'h6006, 3'd1, 8'h00, 64'h0),
          1, 64'h9ABC_0000_0000_0000, 64'hFFFF_FFFF_FFFF_9ABC);

`ifdef MEM_MISALIGN_CHECK_EN
    e = mk(64'h124, 1, 1, 0, 2, 0, 64'h1001, 0, 5'd10);
    vc = valid_cycles;
    issue(e, exp_of(e, 64'h1001, 1), 1'b1);
    @(negedge clk);
    check("mis_valid", dataM_valid, 1);
    check("mis_regwriteM", forward.regwriteM, 0);
    check("mis_no_req", dreq.valid, 0);
    @(posedge clk);
    #1;
    drain();
    check("mis_no_bus", valid_cycles - vc, 0);
`else
    memop(mk(64'h124, 1, 1, 0, 2, 0, 64'h1001, 0, 5'd10),
          mkreq(64'h1000, 3'd2, 8'h00, 64'h0),
          1, 64'h0000_0000_1234_5678, 64'h1234_5678);
    memop(mk(64'h128, 0, 0, 1, 2, 0, 64'h1006,
             64'hDEAD_BEEF, 5'd0),
          mkreq(64'h1004, 3'd2, 8'hF0, 64'hDEAD_BEEF_0000_0000),
          0, 64'h0, 64'h1006);
`endif

    dataM_ready = 1'b0;
    e = mk(64'h200, 1, 0, 0, 0, 0, 64'hA1, 0, 5'd11);
    eb = mk(64'h204, 1, 0, 0, 0, 0, 64'hB2, 0, 5'd12);
    issue(e, exp_of(e, 64'hA1, 0), 1'b1);
    fork
      issue(eb, exp_of(eb, 64'hB2, 0), 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_ready", dataE_ready, 0);
          check("bp_hold", dataM.result, 64'hA1);
        end
        @(posedge clk);
        #1;
        dataM_ready = 1'b1;
      end
    join
    drain();

    resp_en = 1'b0;
    chk_req = 1'b0;
    exp_load = 1'b1;
    e = mk(64'h300, 1, 1, 0, 2, 0, 64'h7000, 0, 5'd13);
    issue(e, exp_of(e, 64'h0, 0), 1'b0);
    @(posedge clk);
    #1;
    check("wait_valid", dreq.valid, 1);
    check("wait_loadbusy", forward.loadbusyM, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", dreq.valid, 0);
    check("rst_mid_dataM_valid", dataM_valid, 0);
    check("rst_mid_loadbusy", forward.loadbusyM, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    resp_data = 64'h1111_2222_3333_4444;
    force_ok = 1'b1;
    @(posedge clk);
    #1;
    force_ok = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("late_ok_dataM_valid", dataM_valid, 0);
      check("late_ok_dreq_valid", dreq.valid, 0);
    end
    @(posedge clk);
    #1;
    resp_en = 1'b1;

    e = mk(64'h400, 1, 0, 0, 0, 0, 64'h77, 0, 5'd14);
    issue(e, exp_of(e, 64'h77, 0), 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
